// File: rtl/inst_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// inst_fetch_sequencer
//
// Purpose:
//   This is the fetch-side partner of the pipeline hazard/stall controller. It
//   owns the PC and drives the instruction-memory request/response handshake,
//   keeping at most one request outstanding. It holds one fetched instruction in
//   a single-entry buffer and issues it into the IF/ID register. When there is
//   nothing to issue it inserts a NOP bubble instead. It also publishes the
//   next/curr/prev instruction window that the controller inspects.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset (synchronous release)
//   imem_req/imem_addr  fetch request and address (address stable while req=1)
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   response; at most one per grant, one or more cycles later
//   stall_id_if_pl      hold the buffered instruction out of ID (bubble issued)
//   stall_pc_increment  hold off launching the next sequential fetch
//   halt                freeze fetch until reset
//   redirect_valid/pc   taken branch/jump from execute (pc[1:0] forced to 0)
//   next_inst           buffered, not-yet-issued instruction (NOP when empty)
//   curr_inst/id_pc     instruction in ID and its PC
//   prev_inst           instruction one stage past ID
//   id_valid            curr_inst is a real instruction, not a bubble
// -----------------------------------------------------------------------------
module inst_fetch_sequencer #(
   parameter int unsigned                  INST_WIDTH_IN_BIT = 32,
   parameter int unsigned                  ADDR_WIDTH        = 32,
   parameter logic [ADDR_WIDTH-1:0]        RESET_PC          = 32'h0000_0000,
   parameter logic [INST_WIDTH_IN_BIT-1:0] NOP_INST          = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         reset_n,
   output logic                         imem_req,
   output logic [ADDR_WIDTH-1:0]        imem_addr,
   input  logic                         imem_gnt,
   input  logic                         imem_rvalid,
   input  logic [INST_WIDTH_IN_BIT-1:0] imem_rdata,
   input  logic                         stall_id_if_pl,
   input  logic                         stall_pc_increment,
   input  logic                         halt,
   input  logic                         redirect_valid,
   input  logic [ADDR_WIDTH-1:0]        redirect_pc,
   output logic [INST_WIDTH_IN_BIT-1:0] next_inst,
   output logic [INST_WIDTH_IN_BIT-1:0] curr_inst,
   output logic [INST_WIDTH_IN_BIT-1:0] prev_inst,
   output logic                         id_valid,
   output logic [ADDR_WIDTH-1:0]        id_pc
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_WAIT      = 3'd2,
      S_FILL      = 3'd3,
      S_IDLE_HOLD = 3'd4,
      S_HALTED    = 3'd5
   } state_e;

   state_e                         state_q, state_d;
   logic [ADDR_WIDTH-1:0]          fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0]          buf_pc_q, buf_pc_d;
   logic [INST_WIDTH_IN_BIT-1:0]   next_inst_q, next_inst_d;
   logic [INST_WIDTH_IN_BIT-1:0]   curr_inst_q, curr_inst_d;
   logic [INST_WIDTH_IN_BIT-1:0]   prev_inst_q, prev_inst_d;
   logic                           id_valid_q, id_valid_d;
   logic [ADDR_WIDTH-1:0]          id_pc_q, id_pc_d;
   logic                           drop_q, drop_d;
   logic                           imem_req_q, imem_req_d;
   logic [ADDR_WIDTH-1:0]          imem_addr_q, imem_addr_d;

   logic                           issue;
   logic [ADDR_WIDTH-1:0]          redir_pc;

   // Targets are word aligned; the low two bits are cleared with a mask.
   assign redir_pc = redirect_pc & ~(ADDR_WIDTH'(3));

   // --------------------------------------------------------------------------
   // Next-state and window logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      buf_pc_d    = buf_pc_q;
      next_inst_d = next_inst_q;
      drop_d      = drop_q;
      issue       = 1'b0;

      if (halt) begin
         // Halt wins over everything. A response still in flight arrives while
         // we sit in HALTED, where rvalid is ignored, so it is consumed and dropped.
         state_d     = S_HALTED;
         next_inst_d = NOP_INST;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_REQ;
               if (redirect_valid) begin
                  fetch_pc_d = redir_pc;
               end
            end

            S_REQ: begin
               if (imem_gnt) begin
                  state_d = S_WAIT;
                  // The grant went out with the old address. The response
                  // must be thrown away when it comes back.
                  if (redirect_valid) begin
                     drop_d     = 1'b1;
                     fetch_pc_d = redir_pc;
                  end
               end else if (redirect_valid) begin
                  fetch_pc_d = redir_pc;
               end
            end

            S_WAIT: begin
               if (imem_rvalid) begin
                  if (drop_q || redirect_valid) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     next_inst_d = imem_rdata;
                     buf_pc_d    = fetch_pc_q;
                     fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(4);
                     state_d     = S_FILL;
                  end
                  if (redirect_valid) begin
                     fetch_pc_d = redir_pc;
                  end
               end else if (redirect_valid) begin
                  drop_d     = 1'b1;
                  fetch_pc_d = redir_pc;
               end
            end

            S_FILL: begin
               if (redirect_valid) begin
                  next_inst_d = NOP_INST;
                  fetch_pc_d  = redir_pc;
                  state_d     = S_REQ;
               end else if (!stall_id_if_pl) begin
                  issue       = 1'b1;
                  next_inst_d = NOP_INST;
                  state_d     = stall_pc_increment ? S_IDLE_HOLD : S_REQ;
               end
            end

            S_IDLE_HOLD: begin
               if (redirect_valid) begin
                  fetch_pc_d = redir_pc;
                  state_d    = S_REQ;
               end else if (!stall_pc_increment) begin
                  state_d = S_REQ;
               end
            end

            S_HALTED: begin
               state_d = S_HALTED;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // The request is registered. It is raised in exactly the cycles spent in REQ.
      imem_req_d  = (state_d == S_REQ);
      imem_addr_d = fetch_pc_d;

      // The window shifts every cycle. A cycle with no issue pushes a bubble into ID.
      prev_inst_d = curr_inst_q;
      curr_inst_d = issue ? next_inst_q : NOP_INST;
      id_valid_d  = issue;
      id_pc_d     = issue ? buf_pc_q : id_pc_q;
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         fetch_pc_q  <= RESET_PC;
         buf_pc_q    <= RESET_PC;
         next_inst_q <= NOP_INST;
         curr_inst_q <= NOP_INST;
         prev_inst_q <= NOP_INST;
         id_valid_q  <= 1'b0;
         id_pc_q     <= RESET_PC;
         drop_q      <= 1'b0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         buf_pc_q    <= buf_pc_d;
         next_inst_q <= next_inst_d;
         curr_inst_q <= curr_inst_d;
         prev_inst_q <= prev_inst_d;
         id_valid_q  <= id_valid_d;
         id_pc_q     <= id_pc_d;
         drop_q      <= drop_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = imem_addr_q;
   assign next_inst = next_inst_q;
   assign curr_inst = curr_inst_q;
   assign prev_inst = prev_inst_q;
   assign id_valid  = id_valid_q;
   assign id_pc     = id_pc_q;

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for inst_fetch_sequencer. A table of per-cycle control inputs and
// expected outputs is applied first. Hand-written sequences then cover the
// drop path, halt and asynchronous reset. A small memory responder grants
// requests and answers with a word derived from the address.
// -----------------------------------------------------------------------------
module tb_inst_fetch_sequencer;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          NV  = 25;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall_id_if_pl;
   logic        stall_pc_increment;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] next_inst;
   logic [31:0] curr_inst;
   logic [31:0] prev_inst;
   logic        id_valid;
   logic [31:0] id_pc;

   inst_fetch_sequencer dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_gnt           (imem_gnt),
      .imem_rvalid        (imem_rvalid),
      .imem_rdata         (imem_rdata),
      .stall_id_if_pl     (stall_id_if_pl),
      .stall_pc_increment (stall_pc_increment),
      .halt               (halt),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc),
      .next_inst          (next_inst),
      .curr_inst          (curr_inst),
      .prev_inst          (prev_inst),
      .id_valid           (id_valid),
      .id_pc              (id_pc)
   );

   int n_vec = 0;
   int n_err = 0;

   // memory responder state
   logic        gnt_en    = 1'b1;
   int          lat       = 1;
   logic        pend      = 1'b0;
   int          cnt       = 0;
   logic [31:0] pend_addr = '0;

   typedef struct {
      logic        sid;
      logic        spc;
      logic        rv;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic [31:0] nxt;
      logic [31:0] cur;
      logic [31:0] prv;
      logic        vld;
      logic [31:0] ipc;
   } vec_t;

   vec_t vecs [NV];

   // addi x1,x0,<addr[11:0]>: distinct word per address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[11:0], 20'h00093};
   endfunction

   function automatic vec_t mk(input logic sid, input logic spc, input logic rv,
                               input logic [31:0] rpc, input logic req,
                               input logic [31:0] addr, input logic [31:0] nxt,
                               input logic [31:0] cur, input logic [31:0] prv,
                               input logic vld, input logic [31:0] ipc);
      vec_t v;
      v.sid = sid; v.spc = spc; v.rv = rv; v.rpc = rpc; v.req = req;
      v.addr = addr; v.nxt = nxt; v.cur = cur; v.prv = prv; v.vld = vld; v.ipc = ipc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // One clock: capture a grant, advance, then update rvalid/gnt after the edge.
   task automatic tick();
      if (imem_req && imem_gnt && !pend) begin
         pend      = 1'b1;
         pend_addr = imem_addr;
         cnt       = lat;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend) begin
         if (cnt <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
         end else begin
            cnt--;
         end
      end
      imem_gnt = imem_req && gnt_en;
   endtask

   task automatic set_gnt_en(input logic v);
      gnt_en   = v;
      imem_gnt = imem_req && v;
   endtask

   task automatic show(input string tag);
      $display("%s req=%0b addr=%08h next=%08h curr=%08h prev=%08h vld=%0b id_pc=%08h",
               tag, imem_req, imem_addr, next_inst, curr_inst, prev_inst, id_valid, id_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n            = 1'b0;
      imem_gnt           = 1'b0;
      imem_rvalid        = 1'b0;
      imem_rdata         = '0;
      stall_id_if_pl     = 1'b0;
      stall_pc_increment = 1'b0;
      halt               = 1'b0;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;

      //            sid  spc  rv   rpc     req  addr    next        curr        prev        vld  id_pc
      vecs[0]  = mk(0,   0,   0,   32'h0,  1,   32'h00, NOP,        NOP,        NOP,        0,   32'h00);
      vecs[1]  = mk(0,   0,   0,   32'h0,  0,   32'h00, NOP,        NOP,        NOP,        0,   32'h00);
      vecs[2]  = mk(0,   0,   0,   32'h0,  0,   32'h04, 32'h00000093, NOP,      NOP,        0,   32'h00);
      vecs[3]  = mk(0,   0,   0,   32'h0,  1,   32'h04, NOP,        32'h00000093, NOP,      1,   32'h00);
      vecs[4]  = mk(0,   0,   0,   32'h0,  0,   32'h04, NOP,        NOP,        32'h00000093, 0, 32'h00);
      vecs[5]  = mk(0,   0,   0,   32'h0,  0,   32'h08, 32'h00400093, NOP,      NOP,        0,   32'h00);
      vecs[6]  = mk(0,   0,   0,   32'h0,  1,   32'h08, NOP,        32'h00400093, NOP,      1,   32'h04);
      vecs[7]  = mk(0,   0,   0,   32'h0,  0,   32'h08, NOP,        NOP,        32'h00400093, 0, 32'h04);
      vecs[8]  = mk(0,   0,   0,   32'h0,  0,   32'h0C, 32'h00800093, NOP,      NOP,        0,   32'h04);
      vecs[9]  = mk(1,   0,   0,   32'h0,  0,   32'h0C, 32'h00800093, NOP,      NOP,        0,   32'h04);
      vecs[10] = mk(1,   0,   0,   32'h0,  0,   32'h0C, 32'h00800093, NOP,      NOP,        0,   32'h04);
      vecs[11] = mk(0,   0,   0,   32'h0,  1,   32'h0C, NOP,        32'h00800093, NOP,      1,   32'h08);
      vecs[12] = mk(0,   0,   0,   32'h0,  0,   32'h0C, NOP,        NOP,        32'h00800093, 0, 32'h08);
      vecs[13] = mk(0,   0,   1,   32'h43, 1,   32'h40, NOP,        NOP,        NOP,        0,   32'h08);
      vecs[14] = mk(0,   0,   0,   32'h0,  0,   32'h40, NOP,        NOP,        NOP,        0,   32'h08);
      vecs[15] = mk(0,   0,   0,   32'h0,  0,   32'h44, 32'h04000093, NOP,      NOP,        0,   32'h08);
      vecs[16] = mk(0,   1,   0,   32'h0,  0,   32'h44, NOP,        32'h04000093, NOP,      1,   32'h40);
      vecs[17] = mk(0,   1,   0,   32'h0,  0,   32'h44, NOP,        NOP,        32'h04000093, 0, 32'h40);
      vecs[18] = mk(0,   0,   0,   32'h0,  1,   32'h44, NOP,        NOP,        NOP,        0,   32'h40);
      vecs[19] = mk(0,   0,   0,   32'h0,  0,   32'h44, NOP,        NOP,        NOP,        0,   32'h40);
      vecs[20] = mk(0,   0,   0,   32'h0,  0,   32'h48, 32'h04400093, NOP,      NOP,        0,   32'h40);
      vecs[21] = mk(0,   0,   1,   32'h80, 1,   32'h80, NOP,        NOP,        NOP,        0,   32'h40);
      vecs[22] = mk(0,   0,   0,   32'h0,  0,   32'h80, NOP,        NOP,        NOP,        0,   32'h40);
      vecs[23] = mk(0,   0,   0,   32'h0,  0,   32'h84, 32'h08000093, NOP,      NOP,        0,   32'h40);
      vecs[24] = mk(0,   0,   0,   32'h0,  1,   32'h84, NOP,        32'h08000093, NOP,      1,   32'h80);

      // ---------------- reset state ----------------
      tick();
      tick();
      show("reset");
      check("rst.req",   {31'd0, imem_req}, 32'd0);
      check("rst.addr",  imem_addr, 32'h0);
      check("rst.next",  next_inst, NOP);
      check("rst.curr",  curr_inst, NOP);
      check("rst.prev",  prev_inst, NOP);
      check("rst.valid", {31'd0, id_valid}, 32'd0);
      check("rst.id_pc", id_pc, 32'h0);
      reset_n = 1'b1;

      // ---------------- table: straight line, stall, redirects ----------------
      for (int i = 0; i < NV; i++) begin
         stall_id_if_pl     = vecs[i].sid;
         stall_pc_increment = vecs[i].spc;
         redirect_valid     = vecs[i].rv;
         redirect_pc        = vecs[i].rpc;
         tick();
         show($sformatf("vec %0d", i));
         check($sformatf("v%0d.req", i),   {31'd0, imem_req}, {31'd0, vecs[i].req});
         check($sformatf("v%0d.addr", i),  imem_addr, vecs[i].addr);
         check($sformatf("v%0d.next", i),  next_inst, vecs[i].nxt);
         check($sformatf("v%0d.curr", i),  curr_inst, vecs[i].cur);
         check($sformatf("v%0d.prev", i),  prev_inst, vecs[i].prv);
         check($sformatf("v%0d.valid", i), {31'd0, id_valid}, {31'd0, vecs[i].vld});
         check($sformatf("v%0d.id_pc", i), id_pc, vecs[i].ipc);
      end
      stall_id_if_pl     = 1'b0;
      stall_pc_increment = 1'b0;
      redirect_valid     = 1'b0;

      // ---------------- redirect in WAIT before the response (drop path) ----------------
      lat = 3;
      tick();                                  // granted 0x84, now WAIT
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();                                  // redirect, response still pending
      redirect_valid = 1'b0;
      show("drop redirect");
      check("drop.req0", {31'd0, imem_req}, 32'd0);
      tick();                                  // still waiting
      show("drop wait");
      check("drop.req1", {31'd0, imem_req}, 32'd0);
      check("drop.next1", next_inst, NOP);
      lat = 1;
      tick();                                  // stale response discarded
      show("drop discard");
      check("drop.req2",  {31'd0, imem_req}, 32'd1);
      check("drop.addr2", imem_addr, 32'h100);
      check("drop.next2", next_inst, NOP);
      check("drop.curr2", curr_inst, NOP);
      tick();
      tick();
      show("drop fill");
      check("drop.next3", next_inst, 32'h10000093);
      tick();
      show("drop issue");
      check("drop.curr4",  curr_inst, 32'h10000093);
      check("drop.valid4", {31'd0, id_valid}, 32'd1);
      check("drop.id_pc4", id_pc, 32'h100);

      // ---------------- halt mid-WAIT ----------------
      tick();                                  // granted 0x104, now WAIT, rvalid up
      check("halt.prev0", prev_inst, 32'h10000093);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      show("halt");
      check("halt.req",   {31'd0, imem_req}, 32'd0);
      check("halt.curr",  curr_inst, NOP);
      check("halt.prev",  prev_inst, NOP);
      check("halt.next",  next_inst, NOP);
      check("halt.valid", {31'd0, id_valid}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         redirect_valid = (k == 1);
         redirect_pc    = 32'h200;
         tick();
         show($sformatf("halted %0d", k));
         check($sformatf("halted%0d.req", k),   {31'd0, imem_req}, 32'd0);
         check($sformatf("halted%0d.valid", k), {31'd0, id_valid}, 32'd0);
         check($sformatf("halted%0d.curr", k),  curr_inst, NOP);
      end
      redirect_valid = 1'b0;

      // ---------------- async reset mid-WAIT ----------------
      reset_n = 1'b0;
      #1;
      tick();
      reset_n = 1'b1;
      tick();
      show("restart");
      check("ar.req0",  {31'd0, imem_req}, 32'd1);
      check("ar.addr0", imem_addr, 32'h0);
      set_gnt_en(1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();                                  // redirect while REQ, not granted
      redirect_valid = 1'b0;
      show("req redirect");
      check("ar.req1",  {31'd0, imem_req}, 32'd1);
      check("ar.addr1", imem_addr, 32'h300);
      set_gnt_en(1'b1);
      lat = 2;
      tick();                                  // granted 0x300, now WAIT
      check("ar.req2", {31'd0, imem_req}, 32'd0);
      #2;
      reset_n = 1'b0;                          // asynchronous assertion mid-cycle
      #1;
      show("async reset");
      check("ar.req3",  {31'd0, imem_req}, 32'd0);
      check("ar.addr3", imem_addr, 32'h0);
      check("ar.valid3", {31'd0, id_valid}, 32'd0);
      tick();                                  // stale response appears
      check("ar.rvalid_seen", {31'd0, imem_rvalid}, 32'd1);
      reset_n = 1'b1;
      lat = 1;
      tick();                                  // IDLE -> REQ, stale rvalid ignored
      show("after release");
      check("ar.req4",  {31'd0, imem_req}, 32'd1);
      check("ar.addr4", imem_addr, 32'h0);
      check("ar.next4", next_inst, NOP);
      tick();
      tick();
      check("ar.next5", next_inst, 32'h00000093);
      tick();
      show("restart issue");
      check("ar.curr6",  curr_inst, 32'h00000093);
      check("ar.valid6", {31'd0, id_valid}, 32'd1);
      check("ar.id_pc6", id_pc, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
